// File: rtl/pipe_gap_fifo.sv
// Queue of random pipe gap heights.
// One gap is pushed per debounced key press. The pipe mover pops the head entry.
// gap_y shows the head entry ahead of the pop, or DEFAULT_Y when the queue is empty.
module pipe_gap_fifo #(
  parameter int         DEPTH     = 10,
  parameter logic [6:0] MIN_Y     = 7'd10,
  parameter logic [6:0] MAX_Y     = 7'd90,
  parameter logic [6:0] DEFAULT_Y = 7'd50
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       key_press,
  input  logic       pop,
  output logic [6:0] gap_y,
  output logic [3:0] count,
  output logic       empty,
  output logic       full,
  output logic       overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PUSH, S_HOLD} state_t;

  logic [6:0]    lfsr, mapped;
  logic          sync1, sync2;
  state_t        state, state_nxt;
  logic          push, do_push, do_pop;
  logic [6:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    count_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Free-running LFSR. It is seeded non-zero, so the all-zero lock-up state is never reached.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) lfsr <= 7'h5A;
    else         lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
  end

  // Fold the raw LFSR value into the legal gap-top range.
  always_comb begin
    mapped = lfsr;
    if (lfsr < MIN_Y)      mapped = lfsr + MIN_Y;
    else if (lfsr > MAX_Y) mapped = lfsr - (MAX_Y - MIN_Y + 7'd1);
  end

  // Two-flop synchronizer for the asynchronous key.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key_press;
      sync2 <= sync1;
    end
  end

  // Push FSM state register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Push FSM next-state logic. S_HOLD waits for key release, so a long hold gives a single push.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sync2)  state_nxt = S_PUSH;
      S_PUSH:              state_nxt = S_HOLD;
      S_HOLD:  if (!sync2) state_nxt = S_IDLE;
      default:             state_nxt = S_IDLE;
    endcase
  end

  // Push FSM output logic.
  always_comb begin
    push = (state == S_PUSH);
  end

  // Qualify the requests. When full, a push gets through only alongside a pop,
  // because the pop frees the slot that the write then fills.
  // An empty queue has no bypass, so a pop while empty is simply ignored.
  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    count_nxt = count + {3'd0, do_push} - {3'd0, do_pop};
  end

  // Storage array. It has no reset, so its contents are meaningless until written.
  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem[wr_ptr] <= mapped;
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 4'd0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (do_push)             wr_ptr   <= ptr_inc(wr_ptr);
      if (do_pop)              rd_ptr   <= ptr_inc(rd_ptr);
      if (push && !do_push)    overflow <= 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == 4'd0);
      full  <= (count_nxt == 4'(DEPTH));
    end
  end

  // Show-ahead output of the head entry.
  always_comb begin
    gap_y = empty ? DEFAULT_Y : mem[rd_ptr];
  end

endmodule

// File: tb/tb_pipe_gap_fifo.sv
// Randomized and directed bench for pipe_gap_fifo.
// The reference model is a queue of gap heights plus a schedule of push edges.
module tb_pipe_gap_fifo;
  localparam int DEPTH = 10;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0, key_press = 1'b0, pop = 1'b0;
  logic [6:0] gap_y;
  logic [3:0] count;
  logic       empty, full, overflow;

  int n_chk = 0, n_err = 0;
  int m_lfsr, m_ovf, m_n, m_last;
  int m_q[$], m_pend[$], saved[$];
  bit m_prev;

  pipe_gap_fifo #(.DEPTH(DEPTH)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .key_press(key_press), .pop(pop),
    .gap_y(gap_y), .count(count), .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int lfsr_next(input int s);
    return ((s << 1) & 'h7E) | (((s >> 6) ^ (s >> 5)) & 1);
  endfunction

  function automatic int gap_map(input int r);
    if (r < 10) return r + 10;
    if (r > 90) return r - 81;
    return r;
  endfunction

  function automatic bit pend_has(input int e);
    foreach (m_pend[i]) if (m_pend[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_lfsr = 'h5A;
    m_q.delete();
    m_pend.delete();
    m_ovf = 0;
    m_n = 0;
    m_prev = 1'b0;
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_count"}, count, m_q.size());
    chk({tag, "_empty"}, empty, m_q.size() == 0);
    chk({tag, "_full"}, full, m_q.size() == DEPTH);
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_gap"}, gap_y, (m_q.size() > 0) ? m_q[0] : 50);
  endtask

  // One clock cycle: drive the inputs, predict the result of the edge, then check the outputs.
  // A key rise seen at edge n becomes a push at edge n+3.
  task automatic cyc(input bit k, input bit p);
    bit push_now;
    int val;
    key_press = k;
    pop = p;
    m_n++;
    push_now = pend_has(m_n);
    if (k && !m_prev) m_pend.push_back(m_n + 3);
    m_prev = k;
    val = gap_map(m_lfsr);
    if (push_now) m_last = val;
    if (push_now && p && m_q.size() > 0) begin
      void'(m_q.pop_front());
      m_q.push_back(val);
    end else if (push_now) begin
      if (m_q.size() == DEPTH) m_ovf = 1;
      else m_q.push_back(val);
    end else if (p && m_q.size() > 0) begin
      void'(m_q.pop_front());
    end
    m_lfsr = lfsr_next(m_lfsr);
    @(posedge CLOCK_50);
    #1;
    check_out("cyc");
  endtask

  // One key press of the given length, followed by enough low cycles to let the FSM return to idle.
  task automatic press(input int hold, input bit pop_at_push);
    for (int i = 0; i < hold + 5; i++)
      cyc(i < hold, pop_at_push && pend_has(m_n + 1));
  endtask

  task automatic press_rand(input int hold);
    for (int i = 0; i < hold + 5; i++)
      cyc(i < hold, $urandom_range(0, 3) == 0);
  endtask

  task automatic do_reset();
    key_press = 1'b0;
    pop = 1'b0;
    resetn = 1'b0;
    #2;
    model_reset();
    check_out("rst");
    resetn = 1'b1;
  endtask

  // Wait until a press would push while the LFSR holds the target state, then press.
  task automatic map_test(input int target, input int expv);
    int s, guard;
    for (int i = 0; i < 4; i++) cyc(0, 0);
    guard = 0;
    s = lfsr_next(lfsr_next(lfsr_next(m_lfsr)));
    while (s != target && guard < 200) begin
      cyc(0, 0);
      s = lfsr_next(lfsr_next(lfsr_next(m_lfsr)));
      guard++;
    end
    chk("map_reach", guard < 200, 1);
    press(1, 0);
    chk("map_val", gap_y, expv);
    cyc(0, 1);
  endtask

  initial begin
    model_reset();
    #12;
    check_out("reset");
    @(negedge CLOCK_50);
    resetn = 1'b1;

    // First push: key held through release and kept high for 20 cycles.
    for (int i = 0; i < 3; i++) cyc(1, 0);
    chk("pre_push_count", count, 0);
    cyc(1, 0);
    chk("first_push_gap", gap_y, 86);
    chk("first_push_count", count, 1);
    for (int i = 0; i < 16; i++) cyc(1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0);
    chk("held_count", count, 1);
    cyc(0, 1);

    // Directed mapping through the LFSR states 0x7F, 0x05 and 0x5A.
    map_test('h7F, 46);
    map_test('h05, 15);
    map_test('h5A, 90);

    // Fill to capacity, then one dropped push.
    do_reset();
    for (int i = 0; i < 10; i++) press(2, 0);
    chk("fill_count", count, 10);
    chk("fill_full", full, 1);
    chk("fill_ovf", overflow, 0);
    saved = m_q;
    press(2, 0);
    chk("drop_ovf", overflow, 1);
    chk("drop_count", count, 10);

    // Drain in write order, then pop while empty.
    for (int i = 0; i < 10; i++) begin
      chk("drain_head", gap_y, saved[i]);
      cyc(0, 1);
    end
    chk("drain_count", count, 0);
    chk("drain_gap", gap_y, 50);
    cyc(0, 1);
    chk("empty_pop_count", count, 0);
    chk("empty_pop_gap", gap_y, 50);
    chk("sticky_ovf", overflow, 1);

    // Simultaneous push and pop at count 0, 3 and 10, with the pointers crossing the wrap point.
    do_reset();
    press(1, 1);
    chk("sim0_count", count, 1);
    chk("sim0_gap", gap_y, m_last);
    press(1, 0);
    press(1, 0);
    press(1, 1);
    chk("sim3_count", count, 3);
    for (int i = 0; i < 7; i++) press(1, 0);
    press(1, 1);
    chk("sim10_count", count, 10);
    chk("sim10_ovf", overflow, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1);
    for (int i = 0; i < 6; i++) press(1, 0);
    chk("wrap_count", count, 6);

    // Random presses and pops.
    for (int i = 0; i < 60; i++) press_rand($urandom_range(1, 6));

    // Reset while the FSM is in S_PUSH must abort the write.
    for (int i = 0; i < 4; i++) cyc(0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0);
    do_reset();
    chk("abort_count", count, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0);
    chk("abort_after", count, 0);
    chk("abort_gap", gap_y, 50);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_gap_fifo.md
PIPE_GAP_FIFO -- requirements
Module: pipe_gap_fifo

Interface
REQ-001 Parameter DEPTH, default 10, is the number of queued gap heights.
REQ-002 Parameter MIN_Y, default 7'd10, is the lowest legal gap-top y.
REQ-003 Parameter MAX_Y, default 7'd90, is the highest legal gap-top y (20-pixel opening, 120-line screen).
REQ-004 Parameter DEFAULT_Y, default 7'd50, is the gap y supplied when the queue is empty.
REQ-005 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 key_press  input  1  raw asynchronous player key, active-high.
REQ-008 pop  input  1  one-cycle request from the pipe mover (pipe x wrapped to 0) to consume the head entry.
REQ-009 gap_y  output  7  gap y for the next pipe: the head entry, or DEFAULT_Y when empty.
REQ-010 count  output  4  number of valid entries, 0..DEPTH.
REQ-011 empty  output  1  high when count==0.
REQ-012 full  output  1  high when count==DEPTH.
REQ-013 overflow  output  1  sticky flag, set when a push is dropped because the queue is full.

Function
REQ-014 A 7-bit Fibonacci LFSR SHALL advance every cycle: next = {lfsr[5:0], lfsr[6]^lfsr[5]}; the all-zero state is unreachable.
REQ-015 The mapped value SHALL be: raw<MIN_Y -> raw+MIN_Y; raw>MAX_Y -> raw-(MAX_Y-MIN_Y+1); otherwise raw. This is combinational on the current LFSR state.
REQ-016 key_press SHALL pass through a two-flop synchronizer (sync1, sync2) before use.
REQ-017 The push FSM SHALL have three states: S_IDLE, S_PUSH and S_HOLD.
REQ-018 FSM transitions: S_IDLE->S_PUSH when sync2=1; S_PUSH->S_HOLD unconditionally; S_HOLD->S_IDLE when sync2=0, else stay.
REQ-019 The internal push SHALL be asserted only while in S_PUSH, giving exactly one push per key press regardless of hold time.
REQ-020 Push SHALL write the mapped LFSR value to mem[wr_ptr] at the edge ending S_PUSH.
REQ-021 The key-rise-to-write latency SHALL be 3 edges after sync1 first captures 1.
REQ-022 gap_y SHALL be show-ahead: mem[rd_ptr] when count>0, else DEFAULT_Y, valid in the same cycle.
REQ-023 Pop with count>0 SHALL advance rd_ptr at the next edge.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 Pop while empty SHALL be ignored: no pointer or count change, and gap_y stays DEFAULT_Y.
REQ-026 Push while full SHALL be dropped: no pointer or count change, overflow set to 1.
REQ-027 Simultaneous push and pop with 0<count<DEPTH SHALL perform both operations; count unchanged.
REQ-028 Simultaneous push and pop with count==0 SHALL perform the push only (no bypass); count becomes 1.
REQ-029 Simultaneous push and pop with count==DEPTH SHALL perform both; count stays DEPTH; overflow not set.
REQ-030 count, empty and full SHALL be registered and consistent with the pointers every cycle.
REQ-031 overflow SHALL clear only on reset.

Reset
REQ-032 While resetn=0, the block SHALL immediately force: lfsr=7'h5A, sync1=sync2=0, FSM=S_IDLE, wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overflow=0, gap_y=DEFAULT_Y (50).
REQ-033 Memory contents SHALL be don't-care after reset.
REQ-034 Reset asserted mid-push SHALL abort the write; the FSM returns to S_IDLE.
REQ-035 After reset release the first LFSR states SHALL be 0x5A, 0x35, 0x6B, 0x56.

Verification
REQ-036 Reset: hold resetn=0 then release -> gap_y=50, count=0, empty=1, full=0, overflow=0.
REQ-037 First push: key_press=1 before first edge after release, held 20 cycles -> one write at edge 4 of value 86 (LFSR 0x56); count=1 and gap_y=86 after edge 4, with no further push while held.
REQ-038 Mapping: directed LFSR states 0x7F, 0x05 and 0x5A -> mapped values 46, 15 and 90, checked through a push at the matching cycle.
REQ-039 Fill and overflow: 11 separated presses -> count=10 and full=1 after the 10th; 11th dropped, overflow=1, contents unchanged.
REQ-040 Drain and empty pop: 10 pops return the entries in write order; count=0 and gap_y=50; 11th pop causes no change.
REQ-041 Simultaneous ops and wrap: push and pop on the same cycle at count=0, 3 and 10 -> count becomes 1, 3 and 10; pointers wrap past 9 correctly; reset mid-S_PUSH leaves count=0.
